fifobram_mc: RTL and testbench

FIFOBRAM_MC -- requirements
Module: fifobram_mc

---
 rtl/pipearch_fifobram_pkg.sv | 26 ++
 rtl/fifobram_channel.sv | 130 +++++++++++++
 rtl/fifobram_mc.sv | 57 +++++
 tb/tb_fifobram_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipearch_fifobram_pkg.sv
// Shared mode encoding and decode helpers for the multi-channel FIFO/BRAM block.
package pipearch_fifobram_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BRAM = 2'b01,
    FIFO = 2'b10,
    BOTH = 2'b11
  } t_fifobram_mode;

  // Random-access transfer (addressed write or addressed read).
  function automatic logic is_bram(input logic [1:0] mode);
    return t_fifobram_mode'(mode) == BRAM;
  endfunction

  // Write side: both FIFO and BOTH push at the write pointer.
  function automatic logic is_push(input logic [1:0] mode);
    return (t_fifobram_mode'(mode) == FIFO) || (t_fifobram_mode'(mode) == BOTH);
  endfunction

  // Read side: only FIFO pops; BOTH is a no-op on reads.
  function automatic logic is_pop(input logic [1:0] mode);
    return t_fifobram_mode'(mode) == FIFO;
  endfunction

endpackage

// File: rtl/fifobram_channel.sv
// One channel: a DEPTH x WIDTH block RAM usable as random-access memory or as a
// circular FIFO, with sticky overflow/underflow and a 1- or 2-stage read pipe.
module fifobram_channel
  import pipearch_fifobram_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LOG2_DEPTH   = 5,
  parameter int AF_MARGIN    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [1:0]            wfifobram,
  input  logic                  flush,
  input  logic                  re,
  input  logic [LOG2_DEPTH-1:0] raddr,
  input  logic [1:0]            rfifobram,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rvalid,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int CW = LOG2_DEPTH + 1;
  localparam int DEPTH = 2 ** LOG2_DEPTH;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;

  logic                  push_req, pop_req, push_ok, pop_ok;
  logic                  mem_we, mem_re;
  logic [LOG2_DEPTH-1:0] mem_waddr, mem_raddr;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    push_req  = we && is_push(wfifobram) && !flush;
    pop_req   = re && is_pop(rfifobram) && !flush;
    pop_ok    = pop_req && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push_ok   = push_req && ((count_q != FULL_LEVEL) || pop_ok);
    mem_we    = (we && is_bram(wfifobram)) || push_ok;
    mem_waddr = push_ok ? wptr_q : waddr;
    mem_re    = (re && is_bram(rfifobram)) || pop_ok;
    mem_raddr = pop_ok ? rptr_q : raddr;

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q || (push_req && !push_ok);
    udf_d   = udf_q || (pop_req && !pop_ok);
    if (push_ok) wptr_d = wptr_q + LOG2_DEPTH'(1);
    if (pop_ok)  rptr_d = rptr_q + LOG2_DEPTH'(1);
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd1_q;
  logic             v1_q;

  // NOTE: storage and its read register carry no reset so they map onto block RAM;
  // reading and writing in one block gives read-first behaviour on address collisions.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= wdata;
    if (mem_re) rd1_q <= mem[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) v1_q <= 1'b0;
    else       v1_q <= mem_re;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             v2_q;
    logic [WIDTH-1:0] rd2_q;

    always_ff @(posedge clk) begin
      if (reset) v2_q <= 1'b0;
      else       v2_q <= v1_q;
    end

    always_ff @(posedge clk) rd2_q <= rd1_q;

    assign rvalid = v2_q;
    assign rdata  = rd2_q;
  end else begin : g_lat1
    assign rvalid = v1_q;
    assign rdata  = rd1_q;
  end

  assign count      = count_q;
  assign empty      = (count_q == '0);
  assign almostfull = (count_q >= AF_LEVEL);
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: rtl/fifobram_mc.sv
// NUM_CH independent FIFO/BRAM channels; every bus is packed with channel c at [c*W +: W].
module fifobram_mc #(
  parameter int WIDTH        = 32,
  parameter int LOG2_DEPTH   = 5,
  parameter int NUM_CH       = 2,
  parameter int AF_MARGIN    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH-1:0]                we,
  input  logic [NUM_CH*LOG2_DEPTH-1:0]     waddr,
  input  logic [NUM_CH*WIDTH-1:0]          wdata,
  input  logic [NUM_CH*2-1:0]              wfifobram,
  input  logic [NUM_CH-1:0]                flush,
  input  logic [NUM_CH-1:0]                re,
  input  logic [NUM_CH*LOG2_DEPTH-1:0]     raddr,
  input  logic [NUM_CH*2-1:0]              rfifobram,
  output logic [NUM_CH*WIDTH-1:0]          rdata,
  output logic [NUM_CH-1:0]                rvalid,
  output logic [NUM_CH-1:0]                almostfull,
  output logic [NUM_CH-1:0]                empty,
  output logic [NUM_CH-1:0]                overflow,
  output logic [NUM_CH-1:0]                underflow,
  output logic [NUM_CH*(LOG2_DEPTH+1)-1:0] count
);

  localparam int CW = LOG2_DEPTH + 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifobram_channel #(
      .WIDTH       (WIDTH),
      .LOG2_DEPTH  (LOG2_DEPTH),
      .AF_MARGIN   (AF_MARGIN),
      .READ_LATENCY(READ_LATENCY)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .we        (we[c]),
      .waddr     (waddr[c*LOG2_DEPTH +: LOG2_DEPTH]),
      .wdata     (wdata[c*WIDTH +: WIDTH]),
      .wfifobram (wfifobram[c*2 +: 2]),
      .flush     (flush[c]),
      .re        (re[c]),
      .raddr     (raddr[c*LOG2_DEPTH +: LOG2_DEPTH]),
      .rfifobram (rfifobram[c*2 +: 2]),
      .rdata     (rdata[c*WIDTH +: WIDTH]),
      .rvalid    (rvalid[c]),
      .almostfull(almostfull[c]),
      .empty     (empty[c]),
      .overflow  (overflow[c]),
      .underflow (underflow[c]),
      .count     (count[c*CW +: CW])
    );
  end

endmodule

// File: tb/tb_fifobram_mc.sv
// Self-checking bench for fifobram_mc: directed scenarios plus a randomized run
// compared against a behavioural channel model (arrays, pointers as plain ints, read queue).
module tb_fifobram_mc;
  import pipearch_fifobram_pkg::*;

  localparam int W     = 32;
  localparam int LD    = 5;
  localparam int NCH   = 2;
  localparam int AFM   = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 32;
  localparam int CW    = LD + 1;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0]    we, flush, re;
  logic [NCH*LD-1:0] waddr, raddr;
  logic [NCH*W-1:0]  wdata;
  logic [NCH*2-1:0]  wfifobram, rfifobram;
  logic [NCH*W-1:0]  rdata;
  logic [NCH-1:0]    rvalid, almostfull, empty, overflow, underflow;
  logic [NCH*CW-1:0] count;

  fifobram_mc #(
    .WIDTH(W), .LOG2_DEPTH(LD), .NUM_CH(NCH), .AF_MARGIN(AFM), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .wfifobram(wfifobram), .flush(flush), .re(re), .raddr(raddr),
    .rfifobram(rfifobram), .rdata(rdata), .rvalid(rvalid),
    .almostfull(almostfull), .empty(empty), .overflow(overflow),
    .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  typedef struct {
    int         due;
    logic [W-1:0] data;
    bit         known;
  } rd_t;

  logic [W-1:0] m_mem   [NCH][DEPTH];
  bit           m_known [NCH][DEPTH];
  int           m_wp [NCH], m_rp [NCH], m_cnt [NCH];
  bit           m_ovf [NCH], m_udf [NCH];
  rd_t          m_pend [NCH][$];
  bit           exp_rv [NCH];
  bit           exp_kn [NCH];
  logic [W-1:0] exp_rd [NCH];
  int           cyc = 0;

  task automatic idle();
    we = '0; re = '0; flush = '0; wfifobram = '0; rfifobram = '0;
    waddr = '0; raddr = '0; wdata = '0;
  endtask

  task automatic drv_push(input int c, input logic [W-1:0] d);
    we[c] = 1'b1; wfifobram[c*2 +: 2] = FIFO; wdata[c*W +: W] = d;
  endtask

  task automatic drv_pop(input int c);
    re[c] = 1'b1; rfifobram[c*2 +: 2] = FIFO;
  endtask

  task automatic drv_bwr(input int c, input int a, input logic [W-1:0] d);
    we[c] = 1'b1; wfifobram[c*2 +: 2] = BRAM;
    waddr[c*LD +: LD] = LD'(a); wdata[c*W +: W] = d;
  endtask

  task automatic drv_brd(input int c, input int a);
    re[c] = 1'b1; rfifobram[c*2 +: 2] = BRAM; raddr[c*LD +: LD] = LD'(a);
  endtask

  // Apply the current inputs to the model, advance one clock, then expose expectations.
  task automatic step();
    for (int c = 0; c < NCH; c++) begin
      logic [1:0] wm, rm;
      bit push_req, pop_req, push_ok, pop_ok;
      int wa, ra;
      wm = wfifobram[c*2 +: 2];
      rm = rfifobram[c*2 +: 2];
      wa = int'(waddr[c*LD +: LD]);
      ra = int'(raddr[c*LD +: LD]);
      if (reset) begin
        m_wp[c] = 0; m_rp[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
        m_pend[c].delete();
      end else begin
        push_req = we[c] && (wm == FIFO || wm == BOTH) && !flush[c];
        pop_req  = re[c] && (rm == FIFO) && !flush[c];
        pop_ok   = pop_req && (m_cnt[c] > 0);
        push_ok  = push_req && (m_cnt[c] < DEPTH || pop_ok);
        if (re[c] && rm == BRAM)
          m_pend[c].push_back(rd_t'{cyc + RL - 1, m_mem[c][ra], m_known[c][ra]});
        if (pop_ok)
          m_pend[c].push_back(rd_t'{cyc + RL - 1, m_mem[c][m_rp[c]], m_known[c][m_rp[c]]});
        if (we[c] && wm == BRAM) begin
          m_mem[c][wa] = wdata[c*W +: W]; m_known[c][wa] = 1;
        end
        if (push_ok) begin
          m_mem[c][m_wp[c]] = wdata[c*W +: W]; m_known[c][m_wp[c]] = 1;
          m_wp[c] = (m_wp[c] + 1) % DEPTH;
        end
        if (pop_ok) m_rp[c] = (m_rp[c] + 1) % DEPTH;
        m_cnt[c] = m_cnt[c] + int'(push_ok) - int'(pop_ok);
        if (push_req && !push_ok) m_ovf[c] = 1;
        if (pop_req && !pop_ok)   m_udf[c] = 1;
        if (flush[c]) begin
          m_wp[c] = 0; m_rp[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; m_udf[c] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      exp_rv[c] = 0;
      exp_kn[c] = 0;
      if (m_pend[c].size() > 0 && m_pend[c][0].due == cyc) begin
        exp_rv[c] = 1;
        exp_rd[c] = m_pend[c][0].data;
        exp_kn[c] = m_pend[c][0].known;
        void'(m_pend[c].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    idle(); reset = 1'b1;
    step(); step();
    checks++; if (rvalid !== '0)     begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (count !== '0)      begin errors++; $display("FAIL reset_count: got %h expected 0", count); end
    checks++; if (empty !== '1)      begin errors++; $display("FAIL reset_empty: got %b expected all 1", empty); end
    checks++; if (almostfull !== '0) begin errors++; $display("FAIL reset_af: got %b expected 0", almostfull); end
    checks++; if ({overflow, underflow} !== '0) begin errors++; $display("FAIL reset_flags: got %b expected 0", {overflow, underflow}); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    int seen;
    idle(); flush = '1; step();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); drv_push(0, W'(i)); step();
      checks++; if (count[0 +: CW] !== CW'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count[0 +: CW], i + 1); end
      checks++; if (almostfull[0] !== (i + 1 >= DEPTH - AFM)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almostfull[0], (i + 1 >= DEPTH - AFM)); end
    end
    checks++; if (count[CW +: CW] !== '0) begin errors++; $display("FAIL fill_ch1_count: got %0d expected 0", count[CW +: CW]); end
    idle(); drv_push(0, 32'hDEAD); step();
    checks++; if (overflow[0] !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", overflow[0]); end
    checks++; if (count[0 +: CW] !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count_full: got %0d expected %0d", count[0 +: CW], DEPTH); end
    seen = 0;
    for (int i = 0; i < DEPTH + RL; i++) begin
      idle(); if (i < DEPTH) drv_pop(0); step();
      if (rvalid[0]) begin
        checks++; if (rdata[0 +: W] !== W'(seen)) begin errors++; $display("FAIL fill_pop_data[%0d]: got %0h expected %0h", seen, rdata[0 +: W], seen); end
        seen++;
      end
    end
    checks++; if (seen != DEPTH) begin errors++; $display("FAIL fill_pop_count: got %0d expected %0d", seen, DEPTH); end
    checks++; if (empty[0] !== 1'b1 || count[0 +: CW] !== '0) begin errors++; $display("FAIL fill_drained: got empty=%b count=%0d expected 1/0", empty[0], count[0 +: CW]); end
    checks++; if (underflow[0] !== 1'b0) begin errors++; $display("FAIL fill_no_udf: got %b expected 0", underflow[0]); end
  endtask

  task automatic test_channel_indep();
    int lat;
    logic [W-1:0] d;
    idle(); flush = '1; step();
    idle(); drv_bwr(1, 5, 32'hA5); step();
    for (int i = 0; i < 3; i++) begin idle(); drv_push(0, $urandom); step(); end
    idle(); drv_brd(1, 5); drv_push(0, $urandom);
    lat = 0; d = '0;
    for (int n = 1; n <= RL + 1; n++) begin
      step(); idle();
      if (rvalid[1] && lat == 0) begin lat = n; d = rdata[W +: W]; end
      checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL indep_ch0_rvalid[%0d]: got %b expected 0", n, rvalid[0]); end
    end
    checks++; if (lat != RL) begin errors++; $display("FAIL indep_latency: got %0d expected %0d", lat, RL); end
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL indep_data: got %0h expected a5", d); end
    checks++; if (count[0 +: CW] !== CW'(4)) begin errors++; $display("FAIL indep_ch0_count: got %0d expected 4", count[0 +: CW]); end
    checks++; if (count[CW +: CW] !== '0 || empty[1] !== 1'b1) begin errors++; $display("FAIL indep_ch1_status: got count=%0d empty=%b expected 0/1", count[CW +: CW], empty[1]); end
  endtask

  task automatic test_read_first();
    logic [W-1:0] got[$];
    idle(); drv_bwr(1, 6, 32'd111); step();
    for (int n = 0; n < RL + 3; n++) begin
      idle();
      if (n == 0) begin drv_bwr(1, 6, 32'd222); drv_brd(1, 6); end
      if (n == 1) drv_brd(1, 6);
      step();
      if (rvalid[1]) got.push_back(rdata[W +: W]);
    end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL rf_count: got %0d expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== 32'd111) begin errors++; $display("FAIL rf_old_data: got %0d expected 111", got[0]); end
      checks++; if (got[1] !== 32'd222) begin errors++; $display("FAIL rf_new_data: got %0d expected 222", got[1]); end
    end
  endtask

  task automatic test_push_pop();
    int lvl[3];
    int got, exp_cnt;
    logic [W-1:0] gd;
    lvl = '{0, 10, DEPTH};
    for (int k = 0; k < 3; k++) begin
      idle(); flush[0] = 1'b1; step();
      for (int i = 0; i < lvl[k]; i++) begin idle(); drv_push(0, W'(1000 * k + i)); step(); end
      idle(); drv_push(0, 32'hBEEF); drv_pop(0);
      got = 0; gd = '0;
      for (int n = 0; n <= RL; n++) begin
        step(); idle();
        if (rvalid[0]) begin got++; gd = rdata[0 +: W]; end
      end
      exp_cnt = (lvl[k] == 0) ? 1 : lvl[k];
      checks++; if (count[0 +: CW] !== CW'(exp_cnt)) begin errors++; $display("FAIL pp_count[%0d]: got %0d expected %0d", lvl[k], count[0 +: CW], exp_cnt); end
      checks++; if (underflow[0] !== (lvl[k] == 0)) begin errors++; $display("FAIL pp_udf[%0d]: got %b expected %b", lvl[k], underflow[0], (lvl[k] == 0)); end
      checks++; if (overflow[0] !== 1'b0) begin errors++; $display("FAIL pp_ovf[%0d]: got %b expected 0", lvl[k], overflow[0]); end
      checks++; if (got != ((lvl[k] == 0) ? 0 : 1)) begin errors++; $display("FAIL pp_rvalids[%0d]: got %0d expected %0d", lvl[k], got, (lvl[k] == 0) ? 0 : 1); end
      if (lvl[k] != 0) begin
        checks++; if (gd !== W'(1000 * k)) begin errors++; $display("FAIL pp_data[%0d]: got %0d expected %0d", lvl[k], gd, 1000 * k); end
      end
    end
    idle(); flush[0] = 1'b1; step(); idle();
    checks++; if ({overflow[0], underflow[0], empty[0]} !== 3'b001) begin errors++; $display("FAIL pp_flush_clear: got %b expected 001", {overflow[0], underflow[0], empty[0]}); end
  endtask

  task automatic test_flush();
    int got;
    logic [W-1:0] gd;
    idle(); flush[0] = 1'b1; step();
    for (int i = 0; i < 3; i++) begin idle(); drv_push(0, W'(7 + i)); step(); end
    got = 0; gd = '0;
    idle(); drv_pop(0); step();
    if (rvalid[0]) begin got++; gd = rdata[0 +: W]; end
    idle(); drv_push(0, 32'h55); flush[0] = 1'b1; step();
    if (rvalid[0]) begin got++; gd = rdata[0 +: W]; end
    checks++; if (count[0 +: CW] !== '0 || empty[0] !== 1'b1) begin errors++; $display("FAIL flush_status: got count=%0d empty=%b expected 0/1", count[0 +: CW], empty[0]); end
    for (int n = 0; n < RL; n++) begin
      idle(); step();
      if (rvalid[0]) begin got++; gd = rdata[0 +: W]; end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL flush_rvalid_count: got %0d expected 1", got); end
    checks++; if (gd !== W'(7)) begin errors++; $display("FAIL flush_rvalid_data: got %0d expected 7", gd); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] expq[$];
    logic [W-1:0] d;
    int got, maxc;
    idle(); flush[0] = 1'b1; step();
    got = 0; maxc = 0;
    for (int i = 0; i < 80 + RL; i++) begin
      idle();
      if (i < 80) begin
        if (i % 2 == 0) begin d = $urandom; drv_push(0, d); expq.push_back(d); end
        else drv_pop(0);
      end
      step();
      if (int'(count[0 +: CW]) > maxc) maxc = int'(count[0 +: CW]);
      if (rvalid[0]) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL wrap_extra_rvalid: got %0h expected none", rdata[0 +: W]); end
        else begin
          if (rdata[0 +: W] !== expq[0]) begin errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", got, rdata[0 +: W], expq[0]); end
          void'(expq.pop_front());
        end
        got++;
      end
    end
    checks++; if (got != 40) begin errors++; $display("FAIL wrap_count: got %0d expected 40", got); end
    checks++; if (maxc > 1) begin errors++; $display("FAIL wrap_max_count: got %0d expected <=1", maxc); end
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty[0]); end
  endtask

  task automatic test_random();
    idle(); flush = '1; step();
    for (int i = 0; i < 600; i++) begin
      idle();
      for (int c = 0; c < NCH; c++) begin
        we[c] = 1'($urandom_range(0, 1));
        wfifobram[c*2 +: 2] = 2'($urandom_range(0, 3));
        waddr[c*LD +: LD] = LD'($urandom_range(0, 7));
        wdata[c*W +: W] = $urandom;
        re[c] = 1'($urandom_range(0, 1));
        rfifobram[c*2 +: 2] = 2'($urandom_range(0, 3));
        raddr[c*LD +: LD] = LD'($urandom_range(0, 7));
        flush[c] = ($urandom_range(0, 79) == 0);
      end
      step();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({count[c*CW +: CW], almostfull[c], empty[c], overflow[c], underflow[c]} !==
            {CW'(m_cnt[c]), (m_cnt[c] >= DEPTH - AFM), (m_cnt[c] == 0), m_ovf[c], m_udf[c]}) begin
          errors++;
          $display("FAIL rnd_status ch%0d cyc%0d: got cnt=%0d af=%b e=%b o=%b u=%b expected cnt=%0d o=%b u=%b",
                   c, i, count[c*CW +: CW], almostfull[c], empty[c], overflow[c], underflow[c], m_cnt[c], m_ovf[c], m_udf[c]);
        end
        checks++;
        if (rvalid[c] !== exp_rv[c]) begin errors++; $display("FAIL rnd_rvalid ch%0d cyc%0d: got %b expected %b", c, i, rvalid[c], exp_rv[c]); end
        else if (exp_rv[c] && exp_kn[c]) begin
          checks++;
          if (rdata[c*W +: W] !== exp_rd[c]) begin errors++; $display("FAIL rnd_rdata ch%0d cyc%0d: got %0h expected %0h", c, i, rdata[c*W +: W], exp_rd[c]); end
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    idle(); drv_push(0, 32'd1); drv_push(1, 32'd2); step();
    idle(); drv_brd(0, 5); drv_brd(1, 5); step();
    idle(); reset = 1'b1; step();
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL rst_inflight_rvalid: got %b expected 0", rvalid); end
    step(); reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++; if (rvalid !== '0) begin errors++; $display("FAIL rst_post_rvalid[%0d]: got %b expected 0", n, rvalid); end
    end
    checks++; if (count !== '0 || empty !== '1) begin errors++; $display("FAIL rst_post_status: got count=%h empty=%b expected 0/all 1", count, empty); end
    checks++; if ({almostfull, overflow, underflow} !== '0) begin errors++; $display("FAIL rst_post_flags: got %b expected 0", {almostfull, overflow, underflow}); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_fill();
    test_channel_indep();
    test_read_first();
    test_push_pop();
    test_flush();
    test_wrap();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
